// File: rtl/looper_mix_engine.sv
// Looper mix engine: caches the latest sample per loop channel, applies per-channel gain and
// sums channels one per clock plus aux, saturating the result to SAMPLE_W.
module looper_mix_engine #(
   parameter int unsigned NUM_CH   = 16,
   parameter int unsigned SAMPLE_W = 24,
   parameter int unsigned GAIN_W   = 8,
   parameter int unsigned BANK_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                data_ready,
   input  logic [BANK_W-1:0]   mem_bank,
   input  logic [63:0]         mem_dq_o_b,
   input  logic [NUM_CH-1:0]   playing,
   input  logic                gain_wr,
   input  logic [BANK_W-1:0]   gain_ch,
   input  logic [GAIN_W-1:0]   gain_val,
   input  logic [SAMPLE_W-1:0] auxL,
   input  logic [SAMPLE_W-1:0] auxR,
   input  logic                aux_en,
   input  logic                mix_data,
   output logic [SAMPLE_W-1:0] mixL,
   output logic [SAMPLE_W-1:0] mixR,
   output logic                mix_valid,
   output logic                clip_L,
   output logic                clip_R,
   output logic                busy
);

   localparam int unsigned AccW  = SAMPLE_W + GAIN_W + BANK_W + 2;
   localparam int unsigned ProdW = SAMPLE_W + GAIN_W + 1;
   localparam logic [GAIN_W-1:0] GainUnity = {1'b1, {(GAIN_W-1){1'b0}}};
   localparam logic signed [AccW-1:0] SatMax = {{(AccW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [AccW-1:0] SatMin = {{(AccW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StAccum, StAux, StOut} state_e;

   state_e                     state_q, state_d;
   logic [BANK_W-1:0]          idx_q, idx_d;
   logic signed [AccW-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [SAMPLE_W-1:0]        aux_l_q, aux_l_d, aux_r_q, aux_r_d;
   logic [SAMPLE_W-1:0]        mix_l_q, mix_l_d, mix_r_q, mix_r_d;
   logic                       clip_l_q, clip_l_d, clip_r_q, clip_r_d;
   logic                       valid_q, valid_d;
   logic [2*SAMPLE_W-1:0]      store_q [NUM_CH];
   logic [GAIN_W-1:0]          gain_q  [NUM_CH];

   logic [2*SAMPLE_W-1:0]      cur_s;
   logic [GAIN_W-1:0]          cur_g;
   logic                       cur_p;
   logic signed [ProdW-1:0]    s_l_ext, s_r_ext, g_ext, prod_l, prod_r, sh_l, sh_r;
   logic signed [AccW-1:0]     add_l, add_r;
   logic [SAMPLE_W:0]          sat_l, sat_r;

   if (2 * SAMPLE_W < 64) begin : g_unused_dq
      logic unused_dq;
      assign unused_dq = ^mem_dq_o_b[63:2*SAMPLE_W];
   end

   function automatic logic [SAMPLE_W:0] sat(input logic signed [AccW-1:0] a);
      if (a > SatMax) return {1'b1, SatMax[SAMPLE_W-1:0]};
      if (a < SatMin) return {1'b1, SatMin[SAMPLE_W-1:0]};
      return {1'b0, a[SAMPLE_W-1:0]};
   endfunction

   // Out-of-range bank / gain indices simply match no channel and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            store_q[c] <= '0;
            gain_q[c]  <= GainUnity;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (data_ready && mem_bank == BANK_W'(c)) begin
               store_q[c] <= playing[c] ? mem_dq_o_b[2*SAMPLE_W-1:0] : '0;
            end
            if (gain_wr && gain_ch == BANK_W'(c)) begin
               gain_q[c] <= gain_val;
            end
         end
      end
   end

   always_comb begin
      cur_s = '0;
      cur_g = '0;
      cur_p = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (idx_q == BANK_W'(c)) begin
            cur_s = store_q[c];
            cur_g = gain_q[c];
            cur_p = playing[c];
         end
      end
   end

   // Signed sample times unsigned gain, floor-divided back to unity scale.
   always_comb begin
      s_l_ext = {{(GAIN_W+1){cur_s[2*SAMPLE_W-1]}}, cur_s[2*SAMPLE_W-1:SAMPLE_W]};
      s_r_ext = {{(GAIN_W+1){cur_s[SAMPLE_W-1]}}, cur_s[SAMPLE_W-1:0]};
      g_ext   = {{(SAMPLE_W+1){1'b0}}, cur_g};
      prod_l  = s_l_ext * g_ext;
      prod_r  = s_r_ext * g_ext;
      sh_l    = prod_l >>> (GAIN_W - 1);
      sh_r    = prod_r >>> (GAIN_W - 1);
      add_l   = cur_p ? {{(AccW-ProdW){sh_l[ProdW-1]}}, sh_l} : '0;
      add_r   = cur_p ? {{(AccW-ProdW){sh_r[ProdW-1]}}, sh_r} : '0;
      sat_l   = sat(acc_l_q);
      sat_r   = sat(acc_r_q);
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      acc_l_d  = acc_l_q;
      acc_r_d  = acc_r_q;
      aux_l_d  = aux_l_q;
      aux_r_d  = aux_r_q;
      mix_l_d  = mix_l_q;
      mix_r_d  = mix_r_q;
      clip_l_d = clip_l_q;
      clip_r_d = clip_r_q;
      valid_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mix_data) begin
               aux_l_d = aux_en ? auxL : '0;
               aux_r_d = aux_en ? auxR : '0;
               acc_l_d = '0;
               acc_r_d = '0;
               idx_d   = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            acc_l_d = acc_l_q + add_l;
            acc_r_d = acc_r_q + add_r;
            idx_d   = idx_q + BANK_W'(1);
            if (idx_q == BANK_W'(NUM_CH - 1)) state_d = StAux;
         end
         StAux: begin
            acc_l_d = acc_l_q + {{(AccW-SAMPLE_W){aux_l_q[SAMPLE_W-1]}}, aux_l_q};
            acc_r_d = acc_r_q + {{(AccW-SAMPLE_W){aux_r_q[SAMPLE_W-1]}}, aux_r_q};
            state_d = StOut;
         end
         StOut: begin
            {clip_l_d, mix_l_d} = sat_l;
            {clip_r_d, mix_r_d} = sat_r;
            valid_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         acc_l_q  <= '0;
         acc_r_q  <= '0;
         aux_l_q  <= '0;
         aux_r_q  <= '0;
         mix_l_q  <= '0;
         mix_r_q  <= '0;
         clip_l_q <= 1'b0;
         clip_r_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_l_q  <= acc_l_d;
         acc_r_q  <= acc_r_d;
         aux_l_q  <= aux_l_d;
         aux_r_q  <= aux_r_d;
         mix_l_q  <= mix_l_d;
         mix_r_q  <= mix_r_d;
         clip_l_q <= clip_l_d;
         clip_r_q <= clip_r_d;
         valid_q  <= valid_d;
      end
   end

   assign mixL      = mix_l_q;
   assign mixR      = mix_r_q;
   assign clip_L    = clip_l_q;
   assign clip_R    = clip_r_q;
   assign mix_valid = valid_q;
   assign busy      = (state_q != StIdle) || valid_q;

endmodule

// File: tb/tb_looper_mix_engine.sv
// Scoreboard bench for looper_mix_engine: a 16-channel instance for the main behaviour and an
// 8-channel instance for out-of-range bank handling.
module tb_looper_mix_engine;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic        cl;
      logic        cr;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, data_ready, gain_wr, aux_en, mix_data, mix_data8;
   logic [3:0]  mem_bank, gain_ch;
   logic [63:0] mem_dq_o_b;
   logic [15:0] playing;
   logic [7:0]  gain_val;
   logic [23:0] auxL, auxR;

   logic [23:0] mixL, mixR, mixL8, mixR8;
   logic        mix_valid, clip_L, clip_R, busy;
   logic        mix_valid8, clip_L8, clip_R8, busy8;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   vcnt16 = 0;
   int   issued16 = 0;
   exp_t q16[$];
   exp_t q8[$];
   exp_t e16, e8;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   looper_mix_engine #(.NUM_CH(16), .SAMPLE_W(24), .GAIN_W(8), .BANK_W(4)) dut (
      .clk(clk), .rst(rst), .data_ready(data_ready), .mem_bank(mem_bank),
      .mem_dq_o_b(mem_dq_o_b), .playing(playing), .gain_wr(gain_wr), .gain_ch(gain_ch),
      .gain_val(gain_val), .auxL(auxL), .auxR(auxR), .aux_en(aux_en), .mix_data(mix_data),
      .mixL(mixL), .mixR(mixR), .mix_valid(mix_valid), .clip_L(clip_L), .clip_R(clip_R),
      .busy(busy)
   );

   looper_mix_engine #(.NUM_CH(8), .SAMPLE_W(24), .GAIN_W(8), .BANK_W(4)) dut8 (
      .clk(clk), .rst(rst), .data_ready(data_ready), .mem_bank(mem_bank),
      .mem_dq_o_b(mem_dq_o_b), .playing(playing[7:0]), .gain_wr(gain_wr), .gain_ch(gain_ch),
      .gain_val(gain_val), .auxL(auxL), .auxR(auxR), .aux_en(aux_en), .mix_data(mix_data8),
      .mixL(mixL8), .mixR(mixR8), .mix_valid(mix_valid8), .clip_L(clip_L8), .clip_R(clip_R8),
      .busy(busy8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mix_valid === 1'b1) begin
         vcnt16++;
         if (q16.size() == 0) check("pending16", q16.size() != 0, 1);
         else begin
            e16 = q16.pop_front();
            check("mixL16", mixL, e16.l);
            check("mixR16", mixR, e16.r);
            check("clipL16", clip_L, e16.cl);
            check("clipR16", clip_R, e16.cr);
            check("latency16", cyc, e16.cyc);
         end
      end
      if (mix_valid8 === 1'b1) begin
         if (q8.size() == 0) check("pending8", q8.size() != 0, 1);
         else begin
            e8 = q8.pop_front();
            check("mixL8", mixL8, e8.l);
            check("mixR8", mixR8, e8.r);
            check("clip8", {clip_L8, clip_R8}, {e8.cl, e8.cr});
            check("latency8", cyc, e8.cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_sample(input logic [3:0] ch, input logic [23:0] l, input logic [23:0] r);
      data_ready = 1'b1;
      mem_bank   = ch;
      mem_dq_o_b = {16'h0, l, r};
      tick(1);
      data_ready = 1'b0;
   endtask

   task automatic write_gain(input logic [3:0] ch, input logic [7:0] g);
      gain_wr  = 1'b1;
      gain_ch  = ch;
      gain_val = g;
      tick(1);
      gain_wr  = 1'b0;
   endtask

   // Accepted on the next posedge (cyc+1); result visible NUM_CH+2 edges later.
   task automatic start16(input logic [23:0] l, input logic [23:0] r, input logic cl,
                          input logic cr, input bit expect_it);
      mix_data = 1'b1;
      if (expect_it) begin
         q16.push_back('{l, r, cl, cr, cyc + 19});
         issued16++;
      end
      tick(1);
      mix_data = 1'b0;
   endtask

   task automatic start8(input logic [23:0] l, input logic [23:0] r);
      mix_data8 = 1'b1;
      q8.push_back('{l, r, 1'b0, 1'b0, cyc + 11});
      tick(1);
      mix_data8 = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((q16.size() != 0 || q8.size() != 0) && n < 100) begin
         tick(1);
         n++;
      end
      check("drain", q16.size() + q8.size(), 0);
      tick(2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; data_ready = 1'b0; gain_wr = 1'b0; aux_en = 1'b0;
      mix_data = 1'b0; mix_data8 = 1'b0; mem_bank = '0; gain_ch = '0;
      mem_dq_o_b = '0; playing = 16'hFFFF; gain_val = '0; auxL = '0; auxR = '0;
      tick(3);
      rst = 1'b0;
      tick(1);

      // Reset state and a default-gain mix of an empty store.
      check("rst_mixL", mixL, 0);
      check("rst_mixR", mixR, 0);
      check("rst_valid", mix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_mix8", {busy8, mix_valid8, mixL8}, 0);
      start16(24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
      wait_done();

      // 8-channel instance: bank 15 is out of range and must be dropped.
      write_sample(4'd15, 24'h123456, 24'h654321);
      start8(24'h0, 24'h0);
      wait_done();
      write_sample(4'd7, 24'h000123, 24'hFFFF00);
      start8(24'h000123, 24'hFFFF00);
      wait_done();

      // Unity single channel, with busy framing.
      playing = 16'h0008;
      write_sample(4'd3, 24'h100000, 24'hF00000);
      start16(24'h100000, 24'hF00000, 1'b0, 1'b0, 1'b1);
      check("busy_start", busy, 1);
      tick(17);
      check("busy_late", busy, 1);
      check("valid_early", mix_valid, 0);
      tick(1);
      check("valid_on_time", mix_valid, 1);
      check("busy_at_valid", busy, 1);
      tick(1);
      check("busy_after", busy, 0);
      wait_done();

      // Saturation both directions.
      playing = 16'h000F;
      for (int c = 0; c < 4; c++) write_sample(4'(c), 24'h600000, 24'hA00000);
      start16(24'h7FFFFF, 24'h800000, 1'b1, 1'b1, 1'b1);
      wait_done();

      // Gain and aux, including floor rounding of negative products.
      playing = 16'h0001;
      write_sample(4'd0, 24'h200000, 24'hFFFFFF);
      write_gain(4'd0, 8'd64);
      aux_en = 1'b1; auxL = 24'h000010; auxR = 24'h0;
      start16(24'h100010, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);
      wait_done();
      write_gain(4'd0, 8'd255);
      start16(24'h3FC010, 24'hFFFFFE, 1'b0, 1'b0, 1'b1);
      wait_done();

      // Store gating by playing, aux gating, and mix_data ignored while busy.
      aux_en = 1'b0; auxL = 24'h000055;
      playing = 16'h0020;
      write_sample(4'd5, 24'h111111, 24'h111111);
      playing = 16'h0000;
      write_sample(4'd5, 24'h222222, 24'h222222);
      playing = 16'h0021;
      start16(24'h3FC000, 24'hFFFFFE, 1'b0, 1'b0, 1'b1);
      repeat (3) begin
         tick(1);
         mix_data = 1'b1;
         tick(1);
         mix_data = 1'b0;
      end
      wait_done();
      tick(25);
      check("valid_count16", vcnt16, issued16);

      // Reset mid-mix aborts with no result; a following mix runs from reset state.
      start16(24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("abort_mix", {mixL, mixR}, 0);
      check("abort_flags", {clip_L, clip_R, busy, mix_valid}, 0);
      tick(25);
      check("abort_no_valid", vcnt16, issued16);
      playing = 16'h0003;
      write_sample(4'd0, 24'h200000, 24'h000000);
      write_sample(4'd1, 24'h000100, 24'h7FFFFF);
      aux_en = 1'b1; auxL = 24'hFFFFFF; auxR = 24'h000001;
      start16(24'h2000FF, 24'h7FFFFF, 1'b0, 1'b1, 1'b1);
      wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
